// File: rtl/i2c_regfile_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2c_regfile_target
// Description : I2C target with glitch-filtered SCL/SDA and a byte-wide
//               register file. Supports sub-address auto-increment and read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_regfile_target #(
    parameter logic [6:0] I2C_ADDR   = 7'h70,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] REG_RESET  = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    output logic [NUM_REGS*8-1:0]       regs_flat,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    localparam int unsigned c_ptr_w   = $clog2(NUM_REGS);
    localparam logic [2:0]  c_flt_max = 3'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0] pad_raw, filt, filt_dly_q;
    assign pad_raw = {sda_in, scl_in};

    for (genvar i = 0; i < 2; i++) begin : g_filter
        logic       sync1_q, sync2_q, level_q, level_d;
        logic [2:0] cnt_q, cnt_d;

        // A new level is accepted only after FILTER_LEN consecutive differing samples.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            if (sync2_q != level_q) begin
                if (cnt_q == c_flt_max) level_d = sync2_q;
                else                    cnt_d   = cnt_q + 3'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                level_q <= 1'b1;
                cnt_q   <= '0;
            end else begin
                sync1_q <= pad_raw[i];
                sync2_q <= sync1_q;
                level_q <= level_d;
                cnt_q   <= cnt_d;
            end
        end

        assign filt[i] = level_q;
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
    assign scl_rise  =  filt[0] & ~filt_dly_q[0];
    assign scl_fall  = ~filt[0] &  filt_dly_q[0];
    assign start_det = ~filt[1] &  filt_dly_q[1] & filt[0] & filt_dly_q[0];
    assign stop_det  =  filt[1] & ~filt_dly_q[1] & filt[0] & filt_dly_q[0];
    assign sda_bit   =  filt[1];

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic [c_ptr_w-1:0] ptr_q, ptr_d, ptr_inc;
    logic               rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic               wr_strobe_q, wr_strobe_d;
    logic [c_ptr_w-1:0] wr_index_q, wr_index_d;
    logic [7:0]         regs_q [NUM_REGS];
    logic [7:0]         regs_d [NUM_REGS];
    logic [7:0]         rx_byte;

    assign rx_byte = {shift_q, sda_bit};
    assign ptr_inc = (ptr_q == c_ptr_w'(NUM_REGS - 1)) ? '0 : ptr_q + c_ptr_w'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        regs_d      = regs_q;

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_SUB, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    state_d = S_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_WAIT;
                                end
                            end else if (state_q == S_SUB) begin
                                if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                    ptr_d   = rx_byte[c_ptr_w-1:0];
                                    state_d = S_SUB_ACK;
                                end else begin
                                    state_d = S_WAIT;
                                end
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_strobe_d   = 1'b1;
                                wr_index_d    = ptr_q;
                                ptr_d         = ptr_inc;
                                state_d       = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall drives the ACK, the second releases it and moves on.
                S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d  = S_RDATA;
                                shift_d  = regs_q[ptr_q][6:0];
                                sda_oe_d = ~regs_q[ptr_q][7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_SUB;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                // bit_cnt_q == 0 marks a master ACK already seen in this slot.
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (sda_bit) state_d   = S_WAIT;
                        else         bit_cnt_d = '0;
                    end else if (scl_fall && bit_cnt_q == 4'd0) begin
                        state_d  = S_RDATA;
                        shift_d  = regs_q[ptr_q][6:0];
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_dly_q  <= 2'b11;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            regs_q      <= '{default: REG_RESET};
        end else begin
            filt_dly_q  <= filt;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign regs_flat[8*r +: 8] = regs_q[r];
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_regfile_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_regfile_target
// Description : Bit-banged I2C master with a register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_regfile_target;
    localparam logic [6:0] ADDR  = 7'h70;
    localparam int         NREGS = 16;
    localparam int         FLEN  = 3;
    localparam logic [7:0] RVAL  = 8'h00;
    localparam int         HALF  = 20;

    logic                 clk = 1'b0;
    logic                 rst, scl_m, sda_m, sda_line;
    logic                 sda_oe, wr_strobe, busy;
    logic [NREGS*8-1:0]   regs_flat;
    logic [3:0]           wr_index;

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~sda_oe;

    i2c_regfile_target #(
        .I2C_ADDR(ADDR), .NUM_REGS(NREGS), .FILTER_LEN(FLEN), .REG_RESET(RVAL)
    ) u_dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_regs [NREGS];
    int         m_ptr;
    int         exp_idx[$], obs_idx[$];
    logic [7:0] exp_val[$], obs_val[$];
    logic [7:0] tx_data [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && wr_strobe) begin
            obs_idx.push_back(int'(wr_index));
            obs_val.push_back(regs_flat[int'(wr_index)*8 +: 8]);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Enters and leaves with SCL low; glitch 1 = SCL pulse in low phase, 2 = SDA pulse in high phase.
    task automatic bit_xfer(input logic b, input int glitch, output logic s);
        if (glitch == 1) begin
            clks(7); scl_m = 1'b1; clks(2); scl_m = 1'b0; clks(3);
        end else begin
            clks(12);
        end
        sda_m = b;
        clks(8);
        scl_m = 1'b1;
        if (glitch == 2) begin
            clks(5); sda_m = ~sda_m; clks(2); sda_m = ~sda_m; clks(3);
        end else begin
            clks(10);
        end
        s = sda_line;
        clks(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            clks(12); sda_m = 1'b1; clks(8); scl_m = 1'b1; clks(HALF);
        end
        sda_m = 1'b0;
        clks(HALF);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(12); sda_m = 1'b0; clks(8); scl_m = 1'b1; clks(HALF);
        sda_m = 1'b1;
        clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit, input int gkind, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], (i == gbit) ? gkind : 0, s);
        bit_xfer(1'b1, 0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 0, s);
            d[i] = s;
        end
        bit_xfer(~mack, 0, s);
    endtask

    task automatic wr_txn(input logic [6:0] a, input int sub, input int nd,
                          input int gbyte, input int gbit, input int gkind, input logic do_stop);
        logic ack, match, sub_ok;
        i2c_start();
        send_byte({a, 1'b0}, -1, 0, ack);
        match = (a == ADDR);
        chk("addr_ack", ack, match);
        chk("busy", busy, match);
        send_byte(8'(sub), -1, 0, ack);
        sub_ok = match && (sub < NREGS);
        chk("sub_ack", ack, sub_ok);
        if (sub_ok) m_ptr = sub;
        for (int i = 0; i < nd; i++) begin
            send_byte(tx_data[i], (i == gbyte) ? gbit : -1, gkind, ack);
            chk("wdata_ack", ack, sub_ok);
            if (sub_ok) begin
                exp_idx.push_back(m_ptr);
                exp_val.push_back(tx_data[i]);
                m_regs[m_ptr] = tx_data[i];
                m_ptr = (m_ptr + 1) % NREGS;
            end
        end
        if (do_stop) begin
            i2c_stop();
            chk("busy_idle", busy, 0);
        end
    endtask

    task automatic rd_txn(input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte({ADDR, 1'b1}, -1, 0, ack);
        chk("raddr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d);
            chk("rdata", d, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREGS;
        end
        i2c_stop();
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_state();
        chk("n_strobe", obs_idx.size(), exp_idx.size());
        if (obs_idx.size() == exp_idx.size()) begin
            for (int i = 0; i < exp_idx.size(); i++) begin
                chk("wr_index", obs_idx[i], exp_idx[i]);
                chk("wr_value", obs_val[i], exp_val[i]);
            end
        end
        obs_idx.delete(); obs_val.delete(); exp_idx.delete(); exp_val.delete();
        for (int i = 0; i < NREGS; i++) chk($sformatf("reg%0d", i), regs_flat[i*8 +: 8], m_regs[i]);
    endtask

    initial begin
        logic       s, ack;
        int         kind;
        scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = RVAL;
        m_ptr = 0;
        clks(5);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_index", wr_index, 0);
        chk("rst_busy", busy, 0);
        check_state();
        rst = 1'b0;
        clks(20);

        tx_data[0] = 8'h55; tx_data[1] = 8'h1F;
        wr_txn(ADDR, 10, 2, -1, -1, 0, 1'b1); check_state();

        tx_data[0] = 8'hAA;
        wr_txn(7'h71, 3, 1, -1, -1, 0, 1'b1); check_state();

        tx_data[0] = 8'h01; tx_data[1] = 8'h02; tx_data[2] = 8'h03;
        wr_txn(ADDR, 15, 3, -1, -1, 0, 1'b1); check_state();

        wr_txn(ADDR, 10, 0, -1, -1, 0, 1'b0);
        rd_txn(2);
        rd_txn(1);
        check_state();

        tx_data[0] = 8'h99;
        wr_txn(ADDR, 16, 1, -1, -1, 0, 1'b1); check_state();

        tx_data[0] = 8'h3C; tx_data[1] = 8'hC3;
        wr_txn(ADDR, 7, 2, 0, 3, 1, 1'b1); check_state();
        wr_txn(ADDR, 7, 2, 1, 5, 2, 1'b1); check_state();

        for (int it = 0; it < 14; it++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
                wr_txn(($urandom_range(0, 7) == 0) ? 7'h71 : ADDR, $urandom_range(0, NREGS + 1),
                       $urandom_range(0, 4), -1, -1, 0, 1'b1);
            end else if (kind == 2) begin
                wr_txn(ADDR, $urandom_range(0, NREGS - 1), 0, -1, -1, 0, 1'b0);
                rd_txn($urandom_range(1, 3));
            end else begin
                rd_txn($urandom_range(1, 2));
            end
            check_state();
        end

        // Reset while the target is pulling SDA low for bit 4 of a read byte.
        tx_data[0] = 8'h00;
        wr_txn(ADDR, 5, 1, -1, -1, 0, 1'b1); check_state();
        wr_txn(ADDR, 5, 0, -1, -1, 0, 1'b0);
        i2c_start();
        send_byte({ADDR, 1'b1}, -1, 0, ack);
        chk("raddr_ack", ack, 1);
        for (int i = 0; i < 3; i++) begin
            bit_xfer(1'b1, 0, s);
            chk("rbit_pre_rst", s, 0);
        end
        clks(12);
        chk("oe_pre_rst", sda_oe, 1);
        rst = 1'b1;
        clks(1);
        chk("oe_after_rst", sda_oe, 0);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = RVAL;
        m_ptr = 0;
        check_state();
        clks(7); scl_m = 1'b1; clks(HALF); scl_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_xfer(1'b1, 0, s);
            chk("post_rst_ignored", s, 1);
        end
        i2c_stop();
        chk("busy_post_rst", busy, 0);
        rd_txn(1);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
